num_seq_chk: RTL and testbench
==============================

Name: num_seq_chk

Overview:
- Downstream consumer of the 4-bit digit sequence generator. Samples one digit per valid cycle, checks it against the expected 8-digit pattern 2,0,1,7,0,3,0,1 and acquires frame lock.
- Once locked, it flywheels through isolated errors, counts mismatches and publishes each completed 8-digit frame for display/readback logic.

Parameters:
- DW, 4, digit width in bits
- SEQ_LEN, 8, digits per frame (phase counter is 3 bits; SEQ_LEN fixed at 8)
- EXP_SEQ, 32'h2017_0301, expected frame; digit 0 in bits [31:28], digit 7 in [3:0]
- LOCK_CNT, 2, consecutive error-free frames required to enter LOCKED (1..15)
- MISS_MAX, 3, consecutive mismatching digits in LOCKED that force loss of lock (1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- num_vld  in  1  num is valid this cycle; digit consumed on clk edge when high
- num  in  DW  incoming digit
- locked  out  1  high while FSM is in LOCKED
- phase  out  3  index of next expected digit (0..7)
- frame_pulse  out  1  one-cycle pulse when a full frame completes
- err_pulse  out  1  one-cycle pulse on each mismatch while LOCKED
- err_cnt  out  16  saturating mismatch count while LOCKED
- frame  out  32  last completed frame, digit 0 in [31:28]

Behaviour:
- All outputs registered. On rst: state=HUNT, phase=0, locked=0, frame_pulse=0, err_pulse=0, err_cnt=0, frame=0, good-frame counter=0, miss counter=0, capture shift register=0.
- num_vld=0: state, counters and phase hold. Pulses deassert.
- exp = EXP_SEQ digit selected by phase. Every accepted digit shifts into an 8-digit capture register.
- HUNT:
  - num==EXP_SEQ digit 0 -> SYNC, phase=1, good=0.
  - Otherwise stay in HUNT, phase=0.
- SYNC:
  - num==exp -> phase+1 (wraps 7->0).
  - At wrap, good+1. If good+1==LOCK_CNT -> LOCKED, locked=1 on the same edge.
  - Mismatch: if num==digit 0 -> stay SYNC, phase=1, good=0; else -> HUNT, phase=0, good=0.
- LOCKED:
  - Phase always advances on each accepted digit, matching or not (flywheel).
  - Match -> miss=0.
  - Mismatch -> err_pulse=1 next cycle, err_cnt+1 (holds at 16'hFFFF), miss+1.
  - miss+1==MISS_MAX -> HUNT, locked=0, phase=0, miss=0, good=0; err_cnt retained.
- Frame completion: accepted digit with phase==7 in SYNC (match) or LOCKED (match or mismatch).
  - frame <= capture register including the current digit.
  - frame_pulse=1 for one cycle.
  - In SYNC, the frame completing lock also pulses.
- Latency: outputs reflect a digit one cycle after the edge on which it is accepted.
- Only rst clears err_cnt. rst mid-frame overrides num_vld and returns all state to reset values on that edge.

Test Plan:
- Reset then continuous ideal stream 2,0,1,7,0,3,0,1 repeating, num_vld=1 -> locked rises after the 16th digit is accepted; frame=32'h2017_0301; frame_pulse every 8 cycles from the 8th digit; err_cnt=0.
- Lock, then corrupt one digit (phase 3 sends 4'h9) -> err_pulse single cycle; err_cnt=1; locked stays 1; frame=32'h2019_0301 for that frame, then 32'h2017_0301 again.
- Lock, then send three consecutive wrong digits (4'hF) -> err_cnt=3; locked drops after the 3rd; FSM in HUNT; relocks after 16 further good digits; err_cnt stays 3.
- Start stream at phase 4 (0,3,0,1,2,0,1,7,...) -> HUNT ignores the first 4 digits; SYNC starts at the 2; locked after 20 accepted digits.
- Toggle num_vld 1/0 every cycle on the ideal stream -> same lock and frame results as the continuous case, with timing doubled; no state change on num_vld=0 cycles.
- Assert rst while LOCKED at phase 5 with err_cnt=2 -> next cycle: locked=0, phase=0, err_cnt=0, frame=0; relock requires 16 good digits.

Source files
------------

// File: rtl/num_seq_chk.sv
// Frame-lock checker for the 2,0,1,7,0,3,0,1 digit stream: hunts for frame start,
// confirms alignment over LOCK_CNT clean frames, then flywheels and counts mismatches.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   HUNT   | searching for digit 0 of the pattern; phase held at 0
//   SYNC   | aligned candidate; counting consecutive error-free frames
//   LOCKED | frame lock held; phase free-runs, mismatches counted
module num_seq_chk #(
    parameter int                      DW       = 4,
    parameter int                      SEQ_LEN  = 8,
    parameter logic [DW*SEQ_LEN-1:0]   EXP_SEQ  = 32'h2017_0301,
    parameter int                      LOCK_CNT = 2,
    parameter int                      MISS_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    num_vld,
    input  logic [DW-1:0]           num,
    output logic                    locked,
    output logic [2:0]              phase,
    output logic                    frame_pulse,
    output logic                    err_pulse,
    output logic [15:0]             err_cnt,
    output logic [DW*SEQ_LEN-1:0]   frame
);

    localparam int FW = DW * SEQ_LEN;
    localparam logic [DW-1:0] DIG0 = EXP_SEQ[FW-1 -: DW];
    localparam logic [2:0] LAST_PHASE = 3'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic [3:0]      good_q, good_d;
    logic [3:0]      miss_q, miss_d;
    logic [FW-1:0]   cap_q, cap_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic            fp_q, fp_d;
    logic            ep_q, ep_d;

    logic [FW-1:0]   exp_sh;
    logic [DW-1:0]   exp_dig;
    logic [FW-1:0]   cap_shift;
    logic            match;
    logic            is_dig0;
    logic            at_last;

    // Expected digit: shift the pattern so the current phase lands in the top digit.
    always_comb begin
        exp_sh  = EXP_SEQ << (DW * int'(phase_q));
        exp_dig = exp_sh[FW-1 -: DW];
    end

    assign cap_shift = {cap_q[FW-DW-1:0], num};
    assign match     = (num == exp_dig);
    assign is_dig0   = (num == DIG0);
    assign at_last   = (phase_q == LAST_PHASE);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        good_d    = good_q;
        miss_d    = miss_q;
        cap_d     = cap_q;
        frame_d   = frame_q;
        err_cnt_d = err_cnt_q;
        fp_d      = 1'b0;
        ep_d      = 1'b0;

        if (num_vld) begin
            cap_d = cap_shift;
            unique case (state_q)
                HUNT: begin
                    if (is_dig0) begin
                        state_d = SYNC;
                        phase_d = 3'd1;
                        good_d  = 4'd0;
                    end else begin
                        phase_d = 3'd0;
                    end
                end
                SYNC: begin
                    if (match) begin
                        phase_d = phase_q + 3'd1;
                        if (at_last) begin
                            fp_d    = 1'b1;
                            frame_d = cap_shift;
                            good_d  = good_q + 4'd1;
                            if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
                                state_d = LOCKED;
                                miss_d  = 4'd0;
                            end
                        end
                    end else if (is_dig0) begin
                        // The offending digit may itself be the start of a new frame.
                        phase_d = 3'd1;
                        good_d  = 4'd0;
                    end else begin
                        state_d = HUNT;
                        phase_d = 3'd0;
                        good_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    phase_d = phase_q + 3'd1;
                    if (at_last) begin
                        fp_d    = 1'b1;
                        frame_d = cap_shift;
                    end
                    if (match) begin
                        miss_d = 4'd0;
                    end else begin
                        ep_d   = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (miss_q + 4'd1 == 4'(MISS_MAX)) begin
                            state_d = HUNT;
                            phase_d = 3'd0;
                            miss_d  = 4'd0;
                            good_d  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    phase_d = 3'd0;
                    good_d  = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            phase_q   <= 3'd0;
            good_q    <= 4'd0;
            miss_q    <= 4'd0;
            cap_q     <= '0;
            frame_q   <= '0;
            err_cnt_q <= 16'd0;
            fp_q      <= 1'b0;
            ep_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            cap_q     <= cap_d;
            frame_q   <= frame_d;
            err_cnt_q <= err_cnt_d;
            fp_q      <= fp_d;
            ep_q      <= ep_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign phase       = phase_q;
    assign frame_pulse = fp_q;
    assign err_pulse   = ep_q;
    assign err_cnt     = err_cnt_q;
    assign frame       = frame_q;

endmodule

// File: tb/tb_num_seq_chk.sv
// Self-checking bench for num_seq_chk: directed scenarios plus a long randomized
// run, all compared cycle by cycle against a queue-based behavioural model.
module tb_num_seq_chk;

    localparam int LOCK_CNT = 2;
    localparam int MISS_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        num_vld;
    logic [3:0]  num;
    logic        locked;
    logic [2:0]  phase;
    logic        frame_pulse;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] frame;

    num_seq_chk #(
        .DW(4), .SEQ_LEN(8), .EXP_SEQ(32'h2017_0301),
        .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk), .rst(rst), .num_vld(num_vld), .num(num),
        .locked(locked), .phase(phase), .frame_pulse(frame_pulse),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .frame(frame)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: mode 0=hunting, 1=syncing, 2=locked.
    int unsigned exp_d[8] = '{2, 0, 1, 7, 0, 3, 0, 1};
    int          m_mode, m_phase, m_good, m_miss, m_err;
    int unsigned hist[$];
    logic [31:0] m_frame;
    bit          m_fp, m_ep;

    function automatic logic [31:0] pack_hist();
        logic [31:0] f = 32'h0;
        foreach (hist[i]) f = (f << 4) | 32'(hist[i]);
        return f;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_good = 0; m_miss = 0; m_err = 0;
        m_frame = 32'h0; m_fp = 0; m_ep = 0;
        hist.delete();
        repeat (8) hist.push_back(0);
    endtask

    task automatic model_step(input bit r, input bit v, input int unsigned d);
        bit hit;
        m_fp = 0;
        m_ep = 0;
        if (r) begin
            model_reset();
        end else if (v) begin
            hist.push_back(d);
            void'(hist.pop_front());
            hit = (d == exp_d[m_phase]);
            if ((m_mode == 1 && hit && m_phase == 7) || (m_mode == 2 && m_phase == 7)) begin
                m_frame = pack_hist();
                m_fp = 1;
            end
            if (m_mode == 0) begin
                if (d == exp_d[0]) begin m_mode = 1; m_phase = 1; m_good = 0; end
                else m_phase = 0;
            end else if (m_mode == 1) begin
                if (hit) begin
                    m_phase = (m_phase + 1) % 8;
                    if (m_phase == 0) begin
                        m_good++;
                        if (m_good == LOCK_CNT) m_mode = 2;
                    end
                end else if (d == exp_d[0]) begin
                    m_phase = 1; m_good = 0;
                end else begin
                    m_mode = 0; m_phase = 0; m_good = 0;
                end
            end else begin
                m_phase = (m_phase + 1) % 8;
                if (hit) m_miss = 0;
                else begin
                    m_ep = 1;
                    m_err = (m_err < 65535) ? m_err + 1 : 65535;
                    m_miss++;
                    if (m_miss == MISS_MAX) begin
                        m_mode = 0; m_phase = 0; m_miss = 0; m_good = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("locked", 32'(locked), 32'(m_mode == 2));
        check("phase", 32'(phase), 32'(m_phase));
        check("frame_pulse", 32'(frame_pulse), 32'(m_fp));
        check("err_pulse", 32'(err_pulse), 32'(m_ep));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("frame", frame, m_frame);
    endtask

    task automatic cyc(input bit r, input bit v, input logic [3:0] d);
        rst = r; num_vld = v; num = d;
        @(posedge clk);
        model_step(r, v, int'(d));
        #1;
        compare_all();
    endtask

    int sidx;   // position in the ideal stream
    task automatic ideal(input bit v);
        logic [3:0] d;
        d = 4'(exp_d[sidx]);
        cyc(1'b0, v, d);
        if (v) sidx = (sidx + 1) % 8;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b1, 1'b1, 4'h2);
        sidx = 0;
    endtask

    int fp_cnt;

    initial begin
        rst = 1'b1; num_vld = 1'b0; num = 4'h0;
        model_reset();

        // Reset state and continuous ideal stream
        do_reset();
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_frame", frame, 32'h0);
        fp_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            ideal(1'b1);
            if (frame_pulse) fp_cnt++;
            if (i == 8) check("first_frame_pulse", 32'(frame_pulse), 32'h1);
            if (i == 15) check("lock_not_yet", 32'(locked), 32'h0);
        end
        check("lock_after_16", 32'(locked), 32'h1);
        check("frame_ideal", frame, 32'h2017_0301);
        check("fp_count", 32'(fp_cnt), 32'd2);
        check("err_ideal", 32'(err_cnt), 32'h0);

        // Single corrupted digit at phase 3
        for (int i = 0; i < 3; i++) ideal(1'b1);
        cyc(1'b0, 1'b1, 4'h9); sidx = 4;
        check("single_err_pulse", 32'(err_pulse), 32'h1);
        ideal(1'b1);
        check("err_pulse_one_cycle", 32'(err_pulse), 32'h0);
        for (int i = 0; i < 3; i++) ideal(1'b1);
        check("frame_corrupt", frame, 32'h2019_0301);
        check("err_cnt_1", 32'(err_cnt), 32'h1);
        check("still_locked", 32'(locked), 32'h1);
        for (int i = 0; i < 8; i++) ideal(1'b1);
        check("frame_recovered", frame, 32'h2017_0301);

        // Three consecutive bad digits force loss of lock
        do_reset();
        for (int i = 0; i < 16; i++) ideal(1'b1);
        cyc(1'b0, 1'b1, 4'hF);
        cyc(1'b0, 1'b1, 4'hF);
        check("locked_after_2_miss", 32'(locked), 32'h1);
        cyc(1'b0, 1'b1, 4'hF);
        check("lock_lost", 32'(locked), 32'h0);
        check("err_cnt_3", 32'(err_cnt), 32'h3);
        check("hunt_phase", 32'(phase), 32'h0);
        sidx = 0;
        for (int i = 0; i < 16; i++) ideal(1'b1);
        check("relock", 32'(locked), 32'h1);
        check("err_cnt_kept", 32'(err_cnt), 32'h3);

        // Stream starting mid-frame
        do_reset();
        sidx = 4;
        for (int i = 1; i <= 20; i++) begin
            ideal(1'b1);
            if (i == 4) check("hunt_ignores", 32'(phase), 32'h0);
            if (i == 19) check("midstart_not_yet", 32'(locked), 32'h0);
        end
        check("midstart_lock_20", 32'(locked), 32'h1);

        // num_vld toggling every cycle
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            ideal(i % 2 == 1);
            if (i == 30) check("toggle_not_yet", 32'(locked), 32'h0);
        end
        check("toggle_lock", 32'(locked), 32'h1);
        check("toggle_frame", frame, 32'h2017_0301);
        cyc(1'b0, 1'b0, 4'hF);
        check("hold_phase", 32'(phase), 32'h0);

        // Reset while locked at phase 5 with two errors
        do_reset();
        for (int i = 0; i < 16; i++) ideal(1'b1);
        cyc(1'b0, 1'b1, 4'hE); sidx = 1;
        ideal(1'b1);
        cyc(1'b0, 1'b1, 4'hE); sidx = 3;
        ideal(1'b1); ideal(1'b1);
        check("pre_rst_phase5", 32'(phase), 32'h5);
        check("pre_rst_err2", 32'(err_cnt), 32'h2);
        cyc(1'b1, 1'b1, 4'h3);
        check("rst_locked_clr", 32'(locked), 32'h0);
        check("rst_err_clr", 32'(err_cnt), 32'h0);
        check("rst_frame_clr", frame, 32'h0);
        sidx = 0;
        for (int i = 1; i <= 16; i++) begin
            ideal(1'b1);
            if (i == 15) check("post_rst_not_yet", 32'(locked), 32'h0);
        end
        check("post_rst_relock", 32'(locked), 32'h1);

        // Randomized: dropped valids, corrupt digits, slips and occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int unsigned roll;
            roll = $urandom_range(0, 999);
            if (roll < 3) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
                sidx = 0;
            end else if (roll < 10) begin
                sidx = int'($urandom_range(0, 7));
                ideal(1'b1);
            end else if (roll < 80) begin
                cyc(1'b0, 1'b1, 4'($urandom));
                sidx = (sidx + 1) % 8;
            end else begin
                ideal($urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
